// File: rtl/uart_frame_unpacker_pkg.sv
// Shared definitions for the UART frame unpacker: sync marker, status codes,
// parser state encoding and the parser register bundle.
package uart_frame_unpacker_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [2:0] ERR_OK   = 3'd0;
  localparam logic [2:0] ERR_LEN  = 3'd1;
  localparam logic [2:0] ERR_CSUM = 3'd2;
  localparam logic [2:0] ERR_TMO  = 3'd3;
  localparam logic [2:0] ERR_OVF  = 3'd4;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } state_t;

  // Parser registers grouped so the whole FSM context can be probed in one place.
  typedef struct packed {
    state_t      state;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
    logic [7:0]  csum;
  } parse_t;

endpackage

// File: rtl/uart_frame_unpacker_sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; supports push and pop in the same
// cycle, including when full. Head data reads as zero while empty.
module uart_frame_unpacker_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_frame_unpacker.sv
// Parses SYNC/LEN/data/XOR-checksum frames from UART byte strobes and queues
// big-endian 32-bit words with a last flag; reports status per frame.
module uart_frame_unpacker
  import uart_frame_unpacker_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 4,
  parameter int         MAX_WORDS   = 16,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        word_last,
  output logic        frame_done,
  output logic [2:0]  frame_err
);

  localparam int WLW = $clog2(MAX_WORDS + 1);
  localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  // Output handshake: a word transfers on any cycle with word_valid & word_ready;
  // word_data/word_last hold steady while word_valid is high and word_ready is low.

  parse_t         cur;
  parse_t         nxt;
  logic [WLW-1:0] words_left;
  logic [WLW-1:0] words_left_nxt;
  logic [TW-1:0]  idle_cnt;
  logic [TW-1:0]  idle_cnt_nxt;
  logic           done_nxt;
  logic [2:0]     err_nxt;
  logic           push;
  logic           pop;
  logic           full;
  logic           empty;
  logic [32:0]    push_data;
  logic [32:0]    head;

  assign pop        = word_valid & word_ready;
  assign word_valid = !empty;
  assign word_last  = head[32];
  assign word_data  = head[31:0];

  always_comb begin
    nxt            = cur;
    words_left_nxt = words_left;
    idle_cnt_nxt   = '0;
    done_nxt       = 1'b0;
    err_nxt        = frame_err;
    push           = 1'b0;
    push_data      = {(words_left == WLW'(1)), cur.shift, rx_data};

    if (cur.state != HUNT && !rx_valid && TIMEOUT_CYC != 0)
      idle_cnt_nxt = idle_cnt + TW'(1);

    if (rx_valid) begin
      case (cur.state)
        HUNT: begin
          if (rx_data == SYNC_BYTE) nxt.state = LEN;
        end
        LEN: begin
          if (rx_data != 8'd0 && {24'd0, rx_data} <= MAX_WORDS) begin
            nxt.state      = DATA;
            nxt.csum       = rx_data;
            nxt.byte_cnt   = 2'd0;
            nxt.shift      = '0;
            words_left_nxt = WLW'(rx_data);
          end else begin
            nxt.state = HUNT;
            done_nxt  = 1'b1;
            err_nxt   = ERR_LEN;
          end
        end
        DATA: begin
          nxt.csum     = cur.csum ^ rx_data;
          nxt.shift    = {cur.shift[15:0], rx_data};
          nxt.byte_cnt = cur.byte_cnt + 2'd1;
          if (cur.byte_cnt == 2'd3) begin
            // A push is only lost when the FIFO is full and nothing leaves this cycle.
            if (full && !pop) begin
              nxt.state    = HUNT;
              nxt.byte_cnt = 2'd0;
              done_nxt     = 1'b1;
              err_nxt      = ERR_OVF;
            end else begin
              push           = 1'b1;
              words_left_nxt = words_left - WLW'(1);
              if (words_left == WLW'(1)) nxt.state = CSUM;
            end
          end
        end
        CSUM: begin
          nxt.state = HUNT;
          done_nxt  = 1'b1;
          err_nxt   = (rx_data == cur.csum) ? ERR_OK : ERR_CSUM;
        end
        default: nxt.state = HUNT;
      endcase
    end else if (cur.state != HUNT && TIMEOUT_CYC != 0 &&
                 idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
      nxt.state    = HUNT;
      nxt.byte_cnt = 2'd0;
      done_nxt     = 1'b1;
      err_nxt      = ERR_TMO;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= '{state: HUNT, byte_cnt: '0, shift: '0, csum: '0};
      words_left <= '0;
      idle_cnt   <= '0;
      frame_done <= 1'b0;
      frame_err  <= ERR_OK;
    end else begin
      cur        <= nxt;
      words_left <= words_left_nxt;
      idle_cnt   <= idle_cnt_nxt;
      frame_done <= done_nxt;
      frame_err  <= err_nxt;
    end
  end

  uart_frame_unpacker_sync_fifo #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

endmodule
